// File: rtl/controller_reset_pulse_pio.sv
// Avalon-MM output port with DATA/SET/CLR access and an optional self-timed pulse overlay.
// The pulse engine is built only when CONTROLLER_PIO_PULSE_EN is defined.
module controller_reset_pulse_pio #(
  parameter int WIDTH        = 3,
  parameter int RESET_VALUE  = 7,
  parameter int PULSE_CYCLES = 16,
  parameter int CNT_W        = $clog2(PULSE_CYCLES + 1)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  output logic [WIDTH-1:0] out_port,
  output logic             pulse_done
);

  localparam logic [1:0] ADDR_DATA  = 2'd0;
  localparam logic [1:0] ADDR_SET   = 2'd1;
  localparam logic [1:0] ADDR_CLR   = 2'd2;
  localparam logic [1:0] ADDR_PULSE = 2'd3;

  logic             wr_en;
  logic [WIDTH-1:0] wd;
  logic [WIDTH-1:0] data_out_q, data_out_d;
  logic             unused_wd;

  assign wr_en     = chipselect & ~write_n;
  assign wd        = writedata[WIDTH-1:0];
  assign unused_wd = ^writedata;

  always_comb begin
    data_out_d = data_out_q;
    if (wr_en) begin
      case (address)
        ADDR_DATA: data_out_d = wd;
        ADDR_SET:  data_out_d = data_out_q | wd;
        ADDR_CLR:  data_out_d = data_out_q & ~wd;
        default:   data_out_d = data_out_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) data_out_q <= WIDTH'(RESET_VALUE);
    else          data_out_q <= data_out_d;
  end

`ifdef CONTROLLER_PIO_PULSE_EN
  logic [WIDTH-1:0] pulse_mask_q, pulse_mask_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             busy_q, busy_d;
  logic             pulse_done_q, pulse_done_d;

  // A PULSE write overrides both the decrement and the terminal-count release of the same edge.
  always_comb begin
    pulse_mask_d = pulse_mask_q;
    count_d      = count_q;
    busy_d       = busy_q;
    pulse_done_d = 1'b0;
    if (busy_q) begin
      if (count_q == CNT_W'(1)) begin
        count_d      = '0;
        busy_d       = 1'b0;
        pulse_done_d = 1'b1;
      end else begin
        count_d = count_q - CNT_W'(1);
      end
    end
    if (wr_en && address == ADDR_PULSE) begin
      pulse_done_d = 1'b0;
      if (wd != '0) begin
        pulse_mask_d = wd;
        count_d      = CNT_W'(PULSE_CYCLES);
        busy_d       = 1'b1;
      end else begin
        count_d = '0;
        busy_d  = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pulse_mask_q <= '0;
      count_q      <= '0;
      busy_q       <= 1'b0;
      pulse_done_q <= 1'b0;
    end else begin
      pulse_mask_q <= pulse_mask_d;
      count_q      <= count_d;
      busy_q       <= busy_d;
      pulse_done_q <= pulse_done_d;
    end
  end

  assign out_port   = data_out_q | (busy_q ? pulse_mask_q : '0);
  assign pulse_done = pulse_done_q;

  always_comb begin
    readdata = '0;
    case (address)
      ADDR_DATA:  readdata[WIDTH-1:0] = data_out_q;
      ADDR_SET:   readdata[WIDTH-1:0] = out_port;
      ADDR_CLR:   readdata[WIDTH-1:0] = pulse_mask_q;
      ADDR_PULSE: begin
        readdata[31]        = busy_q;
        readdata[CNT_W-1:0] = count_q;
      end
      default:    readdata = '0;
    endcase
  end
`else
  logic unused_pulse_cfg;
  assign unused_pulse_cfg = ^CNT_W'(PULSE_CYCLES);

  assign out_port   = data_out_q;
  assign pulse_done = 1'b0;

  always_comb begin
    readdata = '0;
    case (address)
      ADDR_DATA: readdata[WIDTH-1:0] = data_out_q;
      ADDR_SET:  readdata[WIDTH-1:0] = out_port;
      default:   readdata = '0;
    endcase
  end
`endif

endmodule

// File: tb/tb_controller_reset_pulse_pio.sv
// Scoreboard bench for controller_reset_pulse_pio; adapts its expectations to CONTROLLER_PIO_PULSE_EN.
module tb_controller_reset_pulse_pio;

  localparam int W  = 3;
  localparam int RV = 7;
  localparam int PC = 16;

  typedef struct {
    logic [W-1:0] outPort;
    logic         done;
    logic [1:0]   rdAddr;
    logic [31:0]  rdData;
    string        tag;
  } expect_t;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic [1:0]   address = '0;
  logic         chipselect = 1'b0;
  logic         write_n = 1'b1;
  logic [31:0]  writedata = '0;
  logic [31:0]  readdata;
  logic [W-1:0] out_port;
  logic         pulse_done;

  expect_t      sbQueue[$];
  int           checkCount = 0;
  int           passCount = 0;

  logic [W-1:0] mData;
  logic [W-1:0] mMask;
  int           mLeft;

  controller_reset_pulse_pio #(
    .WIDTH(W), .RESET_VALUE(RV), .PULSE_CYCLES(PC)
  ) dut (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .readdata(readdata),
    .out_port(out_port), .pulse_done(pulse_done)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checkCount++;
    if (actual === expected) passCount++;
    else $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", tag, actual, expected, $time);
  endtask

  function automatic logic [W-1:0] modelOut();
    return mData | ((mLeft > 0) ? mMask : '0);
  endfunction

  function automatic logic [31:0] modelRead(input logic [1:0] a);
    logic [31:0] r;
    r = '0;
    case (a)
      2'd0: r[W-1:0] = mData;
      2'd1: r[W-1:0] = modelOut();
`ifdef CONTROLLER_PIO_PULSE_EN
      2'd2: r[W-1:0] = mMask;
      2'd3: begin
        r[31]  = (mLeft > 0);
        r[7:0] = 8'(mLeft);
      end
`endif
      default: r = '0;
    endcase
    return r;
  endfunction

  // Drives one bus cycle, advances the model by one edge, queues the expectation, then checks it.
  task automatic applyStimulus(input string tag, input bit wr, input logic [1:0] addr,
                               input logic [31:0] wd, input logic [1:0] rdAddr);
    expect_t e;
    logic    doneNext;
    expect_t got;
    chipselect = wr;
    write_n    = !wr;
    address    = addr;
    writedata  = wd;
    doneNext = 1'b0;
    if (mLeft > 0) begin
      mLeft--;
      if (mLeft == 0) doneNext = 1'b1;
    end
    if (wr) begin
      case (addr)
        2'd0: mData = wd[W-1:0];
        2'd1: mData = mData | wd[W-1:0];
        2'd2: mData = mData & ~wd[W-1:0];
        default: begin
`ifdef CONTROLLER_PIO_PULSE_EN
          doneNext = 1'b0;
          if (wd[W-1:0] != '0) begin
            mMask = wd[W-1:0];
            mLeft = PC;
          end else begin
            mLeft = 0;
          end
`endif
        end
      endcase
    end
    e.outPort = modelOut();
    e.done    = doneNext;
    e.rdAddr  = rdAddr;
    e.rdData  = modelRead(rdAddr);
    e.tag     = tag;
    sbQueue.push_back(e);
    @(posedge clk);
    #1;
    chipselect = 1'b0;
    write_n    = 1'b1;
    address    = rdAddr;
    #1;
    if (sbQueue.size() == 0) begin
      checkOutput({tag, "_queue"}, 32'd0, 32'd1);
    end else begin
      got = sbQueue.pop_front();
      checkOutput({got.tag, "_out"}, 32'(out_port), 32'(got.outPort));
      checkOutput({got.tag, "_done"}, 32'(pulse_done), 32'(got.done));
      checkOutput({got.tag, "_rd"}, readdata, got.rdData);
    end
  endtask

  task automatic idle(input string tag, input int n, input logic [1:0] rdAddr);
    for (int i = 0; i < n; i++) applyStimulus(tag, 1'b0, 2'd0, 32'd0, rdAddr);
  endtask

  task automatic modelReset();
    mData = W'(RV);
    mMask = '0;
    mLeft = 0;
    sbQueue.delete();
  endtask

  initial begin
    modelReset();
    #12;
    checkOutput("rst_out", 32'(out_port), 32'(RV));
    checkOutput("rst_done", 32'(pulse_done), 32'd0);
    address = 2'd0; #1;
    checkOutput("rst_rd0", readdata, 32'(RV));
    address = 2'd3; #1;
    checkOutput("rst_rd3", readdata, 32'd0);
    address = 2'd2; #1;
    checkOutput("rst_rd2", readdata, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);

    applyStimulus("data0", 1'b1, 2'd0, 32'd0, 2'd0);
    applyStimulus("set2", 1'b1, 2'd1, 32'd2, 2'd1);
    applyStimulus("clr2", 1'b1, 2'd2, 32'd2, 2'd0);
    applyStimulus("dataUpper", 1'b1, 2'd0, 32'hFFFF_FFF8, 2'd0);

    applyStimulus("pulse5", 1'b1, 2'd3, 32'd5, 2'd3);
    idle("pulse5_run", 18, 2'd3);
    applyStimulus("maskKept", 1'b0, 2'd0, 32'd0, 2'd2);

    applyStimulus("pulseA", 1'b1, 2'd3, 32'd5, 2'd3);
    idle("pulseA_run", 11, 2'd3);
    applyStimulus("restart1", 1'b1, 2'd3, 32'd1, 2'd3);
    idle("restart_run", 18, 2'd1);

    applyStimulus("pulseB", 1'b1, 2'd3, 32'd5, 2'd3);
    idle("pulseB_run", 4, 2'd1);
    applyStimulus("cancel", 1'b1, 2'd3, 32'd0, 2'd3);
    idle("cancel_run", 3, 2'd3);

    applyStimulus("pulseC", 1'b1, 2'd3, 32'd5, 2'd3);
    idle("pulseC_run", 8, 2'd3);
    applyStimulus("setMid", 1'b1, 2'd1, 32'd2, 2'd1);
    idle("setMid_run", 10, 2'd1);
    applyStimulus("clrAll", 1'b1, 2'd2, 32'd7, 2'd0);

    applyStimulus("pulseD", 1'b1, 2'd3, 32'd5, 2'd3);
    idle("pulseD_run", 4, 2'd1);
    #3;
    reset_n = 1'b0;
    #1;
    modelReset();
    checkOutput("midRst_out", 32'(out_port), 32'(RV));
    address = 2'd3; #1;
    checkOutput("midRst_rd3", readdata, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    idle("afterRst", 20, 2'd3);

    $display("[TB] %0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
